// File: rtl/event_blinker.sv
// event_blinker: stretches single-cycle event pulses into visible LED blinks.
// Ports: clk, rst, event_in, clear_overflow -> led_out, busy, pending_count, overflow.
module event_blinker #(
  parameter int ON_CYCLES   = 12_500_000,
  parameter int OFF_CYCLES  = 12_500_000,
  parameter int MAX_PENDING = 15
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           event_in,
  input  logic                           clear_overflow,
  output logic                           led_out,
  output logic                           busy,
  output logic [$clog2(MAX_PENDING+1)-1:0] pending_count,
  output logic                           overflow
);

  localparam int MAXC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TW   = $clog2(MAXC + 1);
  localparam int PW   = $clog2(MAX_PENDING + 1);

  localparam logic [TW-1:0] ON_LAST  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(OFF_CYCLES - 1);
  localparam logic [PW-1:0] P_MAX    = PW'(MAX_PENDING);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;

  logic slot;
  logic take;
  logic drop;

  // A blink may start from IDLE or in the very last OFF cycle, so
  // back-to-back blinks keep exactly OFF_CYCLES of dark between them.
  assign slot = (state == IDLE) ||
                ((state == OFF) && (timer == OFF_LAST));
  assign take = slot && ((pending_count != '0) || event_in);
  assign drop = event_in && !take && (pending_count == P_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      timer         <= '0;
      pending_count <= '0;
      overflow      <= 1'b0;
      led_out       <= 1'b0;
      busy          <= 1'b0;
    end else begin
      // Queue: +event -take; a take with an empty queue eats event_in.
      if (event_in && !take) begin
        if (pending_count != P_MAX) begin
          pending_count <= pending_count + 1'b1;
        end
      end else if (!event_in && take) begin
        pending_count <= pending_count - 1'b1;
      end

      // Set wins over clear.
      if (drop) begin
        overflow <= 1'b1;
      end else if (clear_overflow) begin
        overflow <= 1'b0;
      end

      if (take) begin
        state   <= ON;
        timer   <= '0;
        led_out <= 1'b1;
        busy    <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            timer   <= '0;
            led_out <= 1'b0;
            busy    <= 1'b0;
          end
          ON: begin
            if (timer == ON_LAST) begin
              state   <= OFF;
              timer   <= '0;
              led_out <= 1'b0;
            end else begin
              timer   <= timer + 1'b1;
              led_out <= 1'b1;
            end
            busy <= 1'b1;
          end
          OFF: begin
            led_out <= 1'b0;
            if (timer == OFF_LAST) begin
              state <= IDLE;
              timer <= '0;
              busy  <= 1'b0;
            end else begin
              timer <= timer + 1'b1;
              busy  <= 1'b1;
            end
          end
          default: begin
            state   <= IDLE;
            timer   <= '0;
            led_out <= 1'b0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_event_blinker.sv
// tb_event_blinker: scoreboard bench for event_blinker.
// Model tracks elapsed time since blink start and a pending count.
module tb_event_blinker;

  localparam int ON   = 4;
  localparam int OFF  = 3;
  localparam int MAXP = 3;
  localparam int PW   = $clog2(MAXP + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          event_in;
  logic          clear_overflow;
  logic          led_out;
  logic          busy;
  logic [PW-1:0] pending_count;
  logic          overflow;

  typedef struct packed {
    logic          led;
    logic          busy;
    logic [PW-1:0] pend;
    logic          ovf;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  int   rises  = 0;
  logic led_q  = 1'b0;

  bit m_active = 0;
  int m_el     = 0;
  int m_pend   = 0;
  bit m_ovf    = 0;

  always #5 clk = ~clk;

  event_blinker #(
    .ON_CYCLES  (ON),
    .OFF_CYCLES (OFF),
    .MAX_PENDING(MAXP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .event_in      (event_in),
    .clear_overflow(clear_overflow),
    .led_out       (led_out),
    .busy          (busy),
    .pending_count (pending_count),
    .overflow      (overflow)
  );

  task automatic chk(input string n, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus, advance the model, queue expectation.
  task automatic step(input bit ev, input bit clr, input bit r);
    bit   start;
    exp_t e;
    event_in       = ev;
    clear_overflow = clr;
    rst            = r;
    if (r) begin
      m_active = 0;
      m_el     = 0;
      m_pend   = 0;
      m_ovf    = 0;
    end else begin
      start = (!m_active || m_el == ON + OFF - 1) && (m_pend > 0 || ev);
      if (ev && !start && m_pend == MAXP) m_ovf = 1;
      else if (clr) m_ovf = 0;
      m_pend = m_pend + int'(ev) - int'(start);
      if (m_pend > MAXP) m_pend = MAXP;
      if (start) begin
        m_active = 1;
        m_el     = 0;
      end else if (m_active) begin
        m_el++;
        if (m_el == ON + OFF) begin
          m_active = 0;
          m_el     = 0;
        end
      end
    end
    e.led  = m_active && (m_el < ON);
    e.busy = m_active;
    e.pend = PW'(m_pend);
    e.ovf  = m_ovf;
    @(posedge clk);
    #1;
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("led_out", 8'(led_out), 8'(e.led));
      chk("busy", 8'(busy), 8'(e.busy));
      chk("pending_count", 8'(pending_count), 8'(e.pend));
      chk("overflow", 8'(overflow), 8'(e.ovf));
      if (led_out && !led_q) rises++;
      led_q = led_out;
    end
  end

  initial begin
    int r0;
    event_in       = 1'b0;
    clear_overflow = 1'b0;
    rst            = 1'b1;

    // Reset with event_in high.
    step(1, 0, 1);
    step(1, 0, 1);
    repeat (8) step(0, 0, 0);

    // Single event.
    step(1, 0, 0);
    repeat (12) step(0, 0, 0);

    // Burst of three.
    repeat (3) step(1, 0, 0);
    repeat (25) step(0, 0, 0);

    // Overflow, clear colliding with a drop, later plain clear.
    r0 = rises;
    repeat (5) step(1, 0, 0);
    step(1, 1, 0);
    repeat (24) step(0, 0, 0);
    step(0, 1, 0);
    repeat (10) step(0, 0, 0);
    @(negedge clk);
    #1;
    chk("overflow_blinks", 8'(rises - r0), 8'd4);

    // Event exactly in last OFF cycle.
    step(1, 0, 0);
    repeat (ON + OFF - 1) step(0, 0, 0);
    step(1, 0, 0);
    repeat (12) step(0, 0, 0);

    // Reset in the middle of a burst.
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 0, 1);
    repeat (15) step(0, 0, 0);

    // Randomized traffic with occasional dense bursts.
    repeat (3000) begin
      bit dense;
      dense = ($urandom_range(0, 9) == 0);
      step(dense ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 249) == 0));
    end
    repeat (ON + OFF + 2) step(0, 0, 0);

    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
    #1;
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sbq.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/event_blinker.md
Name: event_blinker

Overview:
- Converts single-cycle internal event pulses into human-visible LED blinks, so status events from the serial bus logic (transfer done, error, ack) can be seen on a board LED.
- It is the output-side counterpart of the push-button input conditioning: machine-rate pulses in, slow human-rate on/off pattern out.
- Events are counted, never merged. N events produce N distinct blinks, up to a saturation limit.

Parameters:
- ON_CYCLES, 12_500_000: clock cycles led_out is held high per blink (250 ms at 50 MHz); must be >= 1.
- OFF_CYCLES, 12_500_000: clock cycles led_out is held low after each blink; must be >= 1.
- MAX_PENDING, 15: maximum queued, not-yet-shown events; must be >= 1.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- event_in  input  1  event pulse, sampled every posedge; each high cycle counts as one event
- clear_overflow  input  1  clears the overflow flag
- led_out  output  1  registered LED drive, high during a blink
- busy  output  1  high while not IDLE
- pending_count  output  $clog2(MAX_PENDING+1)  queued events not yet started
- overflow  output  1  sticky flag: an event was dropped

Behaviour:
- Cycle convention: event_in high in cycle k is sampled at the edge closing cycle k. Its effects are visible from cycle k+1.
- Reset: every rst=1 edge forces state=IDLE, timer=0, pending_count=0, overflow=0, led_out=0. rst overrides event_in and clear_overflow. Reset mid-blink drops the blink and all queued events; led_out is 0 the next cycle.
- States and outputs:
  - IDLE, ON, OFF.
  - led_out = (state==ON), registered, no glitches.
  - busy = (state!=IDLE).
- take (start a blink): asserted when (state==IDLE or (state==OFF and timer at last OFF cycle)) and (pending_count>0 or event_in).
- Transitions:
  - take: next state ON, timer reset.
  - ON after exactly ON_CYCLES cycles: next state OFF.
  - OFF after exactly OFF_CYCLES cycles: ON if take, else IDLE.
- Latency: an event in IDLE with an empty queue gives led_out=1 in cycle k+1. There is no gap.
- Blink timing: led_out high for exactly ON_CYCLES cycles, then low for exactly OFF_CYCLES cycles. The OFF gap is enforced even when nothing is pending.
- Queue arithmetic: next pending = pending_count + event_in - take.
  - An event and a take in the same cycle leave the count unchanged.
  - take consumes the incoming event first if pending_count==0.
- Saturation: if pending_count==MAX_PENDING, event_in=1 and no take, the count stays at MAX_PENDING, the event is dropped, and overflow is set.
- overflow: sticky; cleared by clear_overflow=1. If a set and a clear occur in the same cycle, set wins.
- Timer: width $clog2(max(ON_CYCLES,OFF_CYCLES)+1). It never wraps; it is reset at each state change.
- event_in held high for multiple cycles counts one event per cycle. This is by design; upstream must pulse.

Test Plan (ON_CYCLES=4, OFF_CYCLES=3, MAX_PENDING=3):
- Reset: rst=1 for cycles 0-1 with event_in=1 -> led_out=0, busy=0, pending_count=0, overflow=0 through cycle 2.
- Single event: event_in=1 in cycle 10 only -> led_out=1 cycles 11-14 and 0 cycles 15-17; busy=1 cycles 11-17 and 0 at 18; pending_count stays 0.
- Burst: event_in=1 cycles 10-12 -> pending_count 1 at 12, 2 at 13.
  - led_out high cycles 11-14, 18-21 and 25-28.
  - pending_count 1 at 18, 0 at 25; busy falls at cycle 32.
- Overflow: event_in=1 cycles 10-14 -> pending_count 1,2,3,3 (cycles 12-15); overflow=1 from cycle 15.
  - Four blinks total.
  - clear_overflow=1 in cycle 40 -> overflow=0 in cycle 41.
  - clear_overflow and a dropped event in the same cycle -> overflow stays 1.
- Boundary take: single blink, new event_in=1 exactly in the last OFF cycle (cycle 17) -> led_out=1 in cycle 18, busy never drops, pending_count stays 0.
- Reset mid-operation: burst of 3 starting cycle 10, rst=1 in cycle 12 -> led_out=0, pending_count=0, busy=0 from cycle 13; no further blinks.
